hilo_mac_sequencer: RTL
=======================

# hilo_mac_sequencer

Multi-cycle sequencer for the HI/LO multiply-accumulate path, driven by the decode flags `isMul`, `isMadd` and `isMaddu`. It captures operands at issue and runs an iterative shift-add multiply. It then applies the sign correction, optionally accumulates into {HI,LO}, and owns the HI/LO registers. It also raises a pipeline stall while a new multiply or a HI/LO read would collide with an operation in flight.

## Interface
- `WIDTH`, 32: operand width; HI/LO are each `WIDTH` bits.
- `STEP_BITS`, 1: multiplier bits retired per MUL cycle; must divide `WIDTH`; legal values 1, 2, 4.
- `clk` in 1: single clock; all state updates on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: issue request from decode (any of `isMul`/`isMadd`/`isMaddu` set).
- `isMul` in 1: signed multiply, overwrites {HI,LO}.
- `isMadd` in 1: signed multiply, accumulates into {HI,LO}.
- `isMaddu` in 1: unsigned multiply, accumulates into {HI,LO}.
- `rs_val` in WIDTH: multiplicand.
- `rt_val` in WIDTH: multiplier.
- `hilo_read` in 1: decode wants HI or LO this cycle.
- `flush` in 1: abort the in-flight operation.
- `busy` out 1: high in MUL and ACC states.
- `stall` out 1: `busy & (start | hilo_read)`, combinational.
- `done` out 1: one-cycle pulse after HI/LO are updated.
- `hi_out` out WIDTH: HI register.
- `lo_out` out WIDTH: LO register.

## Operation
- States: IDLE, MUL, ACC.
- **IDLE → MUL** on `start` with exactly one op flag set. On that edge, capture:
  - the operation;
  - the signs;
  - for signed ops, |rs| and |rt| (two's-complement negate of negative operands; 0x80000000 is taken as unsigned 2^31);
  - for unsigned ops, the raw operands.
- In IDLE, `start` with zero flags or more than one flag is ignored.
- **MUL**: each cycle adds `multiplicand × rt[STEP_BITS-1:0]` (shifted) into a 2·WIDTH product accumulator and shifts the multiplier right by `STEP_BITS`. The iteration counter counts N = WIDTH/STEP_BITS cycles, then MUL → ACC.
- **ACC**, one cycle:
  - negate the product if the signs differed (signed ops only);
  - `mul`: {HI,LO} ← product;
  - `madd`/`maddu`: {HI,LO} ← {HI,LO} + product, 2·WIDTH modular (carry out discarded, no overflow flag).
  - Then ACC → IDLE, and `done` pulses the following cycle.
- `start` while `busy` is ignored; decode must hold the instruction because `stall` is high.
- `flush` in MUL or ACC: next state IDLE, HI/LO unchanged, no `done`.
- `flush` and `start` in the same IDLE cycle: flush wins, start ignored.
- `hilo_read` in IDLE never stalls; `hi_out`/`lo_out` always show committed values.
- Reset:
  - `hi_out`, `lo_out` = 0;
  - `busy`, `done`, `stall` = 0;
  - state = IDLE;
  - counter and accumulator cleared.
- Reset takes priority over `flush` and `start` and aborts mid-operation with no `done`.

## Timing
- Let `start` be sampled at edge k.
- `busy` is high from cycle k+1 through the ACC cycle at k+N+1.
- HI/LO are updated at edge k+N+2, and `done` is high during cycle k+N+2.
- Latency from issue to committed result is N+2 cycles: 34 for `WIDTH`=32, `STEP_BITS`=1.
- A new `start` is accepted at the earliest in the cycle `done` is high, i.e. back-to-back issue every N+2 cycles.
- `stall` has zero latency: combinational from `busy`, `start` and `hilo_read`.

## Configuration
- `MUL_EARLY_TERM_EN` defined:
  - at the start of each MUL cycle, if the remaining multiplier is zero, go directly to ACC with no add;
  - latency is variable, minimum 3 cycles (rt = 0) and maximum N+2.
- Undefined: fixed N MUL cycles, latency always N+2.

## Structure
- Package `hilo_mac_pkg` holds:
  - the state enum (IDLE/MUL/ACC);
  - the op encoding (`MAC_OP_MUL`, `MAC_OP_MADD`, `MAC_OP_MADDU`);
  - the default `WIDTH` and `STEP_BITS` constants.
- One sub-module, `mac_step_unit`: combinational; takes the multiplicand, `STEP_BITS` of multiplier and the accumulator, and returns the next accumulator value. The FSM, counter and HI/LO registers stay in the top module.

## Test plan
All scenarios use `WIDTH`=32, `STEP_BITS`=1.
1. **Signed mul:** reset, then `mul` rs=7, rt=0xFFFFFFFD → HI=0xFFFFFFFF, LO=0xFFFFFFEB; `done` exactly 34 cycles after the start edge; `busy` high for 33 cycles.
2. **Signed madd:** `mul` 4×4 (LO=16), then `madd` rs=0xFFFFFFFE, rt=5 → HI=0, LO=6.
3. **Unsigned maddu:**
   - from HI/LO=0, `maddu` rs=rt=0xFFFFFFFF → HI=0xFFFFFFFE, LO=0x00000001;
   - wrap case: {HI,LO}=all ones, `maddu` 1×1 → HI=LO=0.
4. **Collisions:** second `start` and `hilo_read` 5 cycles into a `mul` → `stall`=1 in those cycles, second start ignored, HI/LO reflect the first op only; `hilo_read` in IDLE → `stall`=0.
5. **Abort:**
   - `flush` 10 cycles into `mul` rs=3, rt=3 with HI/LO=0x1/0x2 → `busy`=0 next cycle, no `done`, HI/LO stay 0x1/0x2;
   - `rst` mid-op → all outputs 0 next cycle.
6. **Early termination:** with `MUL_EARLY_TERM_EN`, `mul` rs=9, rt=0 → `done` 3 cycles after start, HI=LO=0; rt=1 → `done` 4 cycles after start, LO=9.

Source files
------------

// File: rtl/hilo_mac_pkg.sv
// Shared types and defaults for the HI/LO multiply-accumulate sequencer.
package hilo_mac_pkg;

  localparam int unsigned DEF_WIDTH     = 32;
  localparam int unsigned DEF_STEP_BITS = 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_ACC  = 2'd2
  } mac_state_t;

  typedef enum logic [1:0] {
    MAC_OP_MUL   = 2'd0,
    MAC_OP_MADD  = 2'd1,
    MAC_OP_MADDU = 2'd2
  } mac_op_t;

  // Signed ops take operand magnitudes at issue and fix the sign in ACC.
  function automatic logic op_is_signed(input mac_op_t op);
    return (op != MAC_OP_MADDU);
  endfunction

endpackage

// File: rtl/mac_step_unit.sv
// One shift-add multiply step: adds multiplicand x STEP_BITS multiplier bits
// into the 2*WIDTH product accumulator. Purely combinational.
module mac_step_unit
  import hilo_mac_pkg::*;
#(
  parameter int unsigned WIDTH     = DEF_WIDTH,
  parameter int unsigned STEP_BITS = DEF_STEP_BITS
) (
  input  logic [2*WIDTH-1:0]   multiplicand,
  input  logic [STEP_BITS-1:0] digit,
  input  logic [2*WIDTH-1:0]   acc,
  output logic [2*WIDTH-1:0]   acc_next_c
);

  localparam int unsigned DW = 2 * WIDTH;

  logic [DW-1:0] partial;

  always_comb begin
    partial = '0;
    for (int i = 0; i < int'(STEP_BITS); i++) begin
      if (digit[i]) partial = partial + (multiplicand << i);
    end
    acc_next_c = acc + partial;
  end

endmodule

// File: rtl/hilo_mac_sequencer.sv
// Iterative MUL/MADD/MADDU sequencer owning the HI/LO registers.
// Optional MUL_EARLY_TERM_EN: leave MUL as soon as the remaining multiplier is zero.
module hilo_mac_sequencer
  import hilo_mac_pkg::*;
#(
  parameter int unsigned WIDTH     = DEF_WIDTH,
  parameter int unsigned STEP_BITS = DEF_STEP_BITS
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             isMul,
  input  logic             isMadd,
  input  logic             isMaddu,
  input  logic [WIDTH-1:0] rs_val,
  input  logic [WIDTH-1:0] rt_val,
  input  logic             hilo_read,
  input  logic             flush,
  output logic             busy,
  output logic             stall,
  output logic             done,
  output logic [WIDTH-1:0] hi_out,
  output logic [WIDTH-1:0] lo_out
);

  localparam int unsigned DW    = 2 * WIDTH;
  localparam int unsigned N     = WIDTH / STEP_BITS;
  localparam int unsigned CNT_W = (N > 1) ? $clog2(N) : 1;

  mac_state_t       state_q, state_next;
  mac_op_t          op_q;
  logic             neg_q;
  logic [DW-1:0]    mcand_q;
  logic [WIDTH-1:0] mplier_q;
  logic [CNT_W-1:0] cnt_q;
  logic [DW-1:0]    acc_q;
  logic [WIDTH-1:0] hi_q, lo_q;
  logic             busy_q, done_q;

  logic             issue_ok_c;
  mac_op_t          issue_op_c;
  logic             issue_signed_c;
  logic [WIDTH-1:0] abs_rs_c, abs_rt_c;
  logic             issue_neg_c;
  logic             load_c, step_c, commit_c;
  logic             cnt_last_c;
  logic [DW-1:0]    acc_next_c;
  logic [DW-1:0]    prod_c, hilo_new_c;

  // Issue decode: exactly one op flag must accompany start.
  always_comb begin
    issue_ok_c = 1'b0;
    issue_op_c = MAC_OP_MUL;
    case ({isMul, isMadd, isMaddu})
      3'b100: begin issue_ok_c = start; issue_op_c = MAC_OP_MUL;   end
      3'b010: begin issue_ok_c = start; issue_op_c = MAC_OP_MADD;  end
      3'b001: begin issue_ok_c = start; issue_op_c = MAC_OP_MADDU; end
      default: ;
    endcase
  end

  // Operand magnitudes; the most negative value maps to unsigned 2^(WIDTH-1).
  always_comb begin
    issue_signed_c = op_is_signed(issue_op_c);
    abs_rs_c       = (issue_signed_c && rs_val[WIDTH-1]) ? (~rs_val + WIDTH'(1)) : rs_val;
    abs_rt_c       = (issue_signed_c && rt_val[WIDTH-1]) ? (~rt_val + WIDTH'(1)) : rt_val;
    issue_neg_c    = issue_signed_c & (rs_val[WIDTH-1] ^ rt_val[WIDTH-1]);
  end

  assign cnt_last_c = (cnt_q == CNT_W'(N - 1));

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_next;
  end

  always_comb begin
    state_next = state_q;
    load_c     = 1'b0;
    step_c     = 1'b0;
    commit_c   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!flush && issue_ok_c) begin
          state_next = ST_MUL;
          load_c     = 1'b1;
        end
      end
      ST_MUL: begin
        if (flush) begin
          state_next = ST_IDLE;
        end else begin
`ifdef MUL_EARLY_TERM_EN
          if (mplier_q == '0) begin
            state_next = ST_ACC;
          end else begin
            step_c = 1'b1;
            if (cnt_last_c) state_next = ST_ACC;
          end
`else
          step_c = 1'b1;
          if (cnt_last_c) state_next = ST_ACC;
`endif
        end
      end
      ST_ACC: begin
        state_next = ST_IDLE;
        commit_c   = !flush;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  mac_step_unit #(
    .WIDTH     (WIDTH),
    .STEP_BITS (STEP_BITS)
  ) u_step (
    .multiplicand (mcand_q),
    .digit        (mplier_q[STEP_BITS-1:0]),
    .acc          (acc_q),
    .acc_next_c   (acc_next_c)
  );

  // Sign correction and optional accumulate into {HI,LO}, modulo 2^DW.
  always_comb begin
    prod_c     = neg_q ? (~acc_q + DW'(1)) : acc_q;
    hilo_new_c = (op_q == MAC_OP_MUL) ? prod_c : ({hi_q, lo_q} + prod_c);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      op_q     <= MAC_OP_MUL;
      neg_q    <= 1'b0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
      acc_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      busy_q <= (state_next != ST_IDLE);
      done_q <= commit_c;
      if (load_c) begin
        op_q     <= issue_op_c;
        neg_q    <= issue_neg_c;
        mcand_q  <= DW'(abs_rs_c);
        mplier_q <= abs_rt_c;
        cnt_q    <= '0;
        acc_q    <= '0;
      end else if (step_c) begin
        acc_q    <= acc_next_c;
        mcand_q  <= mcand_q << STEP_BITS;
        mplier_q <= mplier_q >> STEP_BITS;
        cnt_q    <= cnt_q + CNT_W'(1);
      end
      if (commit_c) {hi_q, lo_q} <= hilo_new_c;
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign hi_out = hi_q;
  assign lo_out = lo_q;
  assign stall  = busy_q & (start | hilo_read);

endmodule
